// File: rtl/board_pkg.sv
// Shared board-link definitions: frame size, bitmap type, receiver FSM states
// and the square-to-bit mapping used by both link directions.
package board_pkg;

  localparam int DEFAULT_FRAME_BITS = 64;
  localparam int BOARD_FILES        = 8;
  localparam int BOARD_RANKS        = 8;

  typedef logic [DEFAULT_FRAME_BITS-1:0] boardMap_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spiRxState_t;

  // Square index = rank * 8 + file, so a1 is bit 0 and h8 is bit 63.
  localparam int SQ_A1 = 0;
  localparam int SQ_H1 = 7;
  localparam int SQ_A8 = 56;
  localparam int SQ_H8 = 63;

  function automatic int square_index(input int rank, input int file);
    return rank * BOARD_FILES + file;
  endfunction

  function automatic boardMap_t square_mask(input int rank, input int file);
    boardMap_t m;
    m = '0;
    m[square_index(rank, file)] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/board_spi_rx_if.sv
// SPI pins from the MCU plus the held highlight map presented to the LED driver.
interface board_spi_rx_if
  import board_pkg::*;
#(
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS
);

  logic                  sck;
  logic                  sdi;
  logic                  ce;
  logic [FRAME_BITS-1:0] ledMap;
  logic                  valid;
  logic                  busy;
  logic                  frameErr;

  modport master (
    output sck, sdi, ce,
    input  ledMap, valid, busy, frameErr
  );

  modport slave (
    input  sck, sdi, ce,
    output ledMap, valid, busy, frameErr
  );

endinterface

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous level, with registered rise/fall
// pulses that are high in the same cycle the synchronized level changes.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_stages;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stages <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment is what makes this a chain of flops;
      // every stage and both pulses see the pre-edge stage values.
      r_stages <= {r_stages[STAGES-2:0], i_async};
      // Pulses use the stage about to become o_sync, so they align with it.
      r_rise   <=  r_stages[STAGES-2] & ~r_stages[STAGES-1];
      r_fall   <= ~r_stages[STAGES-2] &  r_stages[STAGES-1];
    end
  end

  assign o_sync = r_stages[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/board_spi_rx.sv
// Oversampling SPI receiver for the MCU-to-board highlight map. Only frames
// with exactly FRAME_BITS bits are committed to ledMap; others set frameErr.
module board_spi_rx
  import board_pkg::*;
#(
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  board_spi_rx_if.slave bus
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sck_sync;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ce_sync;
  logic w_ce_rise;
  logic w_ce_fall;
  logic w_sdi_sync;
  logic w_unused;

  logic [SYNC_STAGES-1:0] r_sdi_pipe;
  spiRxState_t            r_state;
  logic [CNT_W-1:0]       r_count;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [FRAME_BITS-1:0]  r_ledMap;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_frameErr;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.sck),
    .o_sync  (w_sck_sync),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ce_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.ce),
    .o_sync  (w_ce_sync),
    .o_rise  (w_ce_rise),
    .o_fall  (w_ce_fall)
  );

  assign w_unused = &{1'b0, w_sck_sync, w_sck_fall, w_ce_rise};

  // Same depth as sck so sdi_sync is the value sampled alongside the sck rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdi_pipe <= '0;
    end else begin
      r_sdi_pipe <= {r_sdi_pipe[SYNC_STAGES-2:0], bus.sdi};
    end
  end

  assign w_sdi_sync = r_sdi_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset too; an aborted frame must leave
      // nothing behind that a later commit could expose.
      r_state    <= IDLE;
      r_count    <= '0;
      r_shift    <= '0;
      r_ledMap   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ce_sync) begin
            r_count <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          // A rise and a ce fall in the same cycle both apply, so COMMIT
          // sees the count including that last bit.
          if (w_sck_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_sync};
            if (r_count != CNT_SAT) begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          if (w_ce_fall) begin
            r_state <= COMMIT;
          end
        end

        COMMIT: begin
          if (r_count == CNT_FULL) begin
            r_ledMap   <= r_shift;
            r_valid    <= 1'b1;
            r_frameErr <= 1'b0;
          end else begin
            r_frameErr <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ledMap   = r_ledMap;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.frameErr = r_frameErr;

endmodule

// File: doc/board_spi_rx.md
Name: board_spi_rx

Overview:
FPGA-side SPI receiver for the opposite link direction. The MCU uses it to send a 64-bit square-highlight map, one bit per board square, to the board LED driver. It runs entirely in the system clock domain and oversamples the MCU's sck, sdi and ce. Only complete frames are committed to the held output map; malformed frames are flagged and dropped.

Parameters:
FRAME_BITS, 64, bits per frame and width of the output map
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2)

Ports:
clk  input  1  system clock; the only clock in the block
reset  input  1  synchronous, active-high reset
sck  input  1  SPI clock from the MCU, asynchronous, mode 0 (sample on rising edge)
sdi  input  1  SPI data from the MCU, MSB first
ce  input  1  frame enable from the MCU, active-high, asynchronous
ledMap  output  FRAME_BITS  last committed map; bit 63 is the first bit received
valid  output  1  one-cycle pulse when ledMap updates
busy  output  1  high while a frame is in progress
frameErr  output  1  sticky flag: last frame had the wrong bit count; cleared by the next good frame or by reset

Behaviour:
- Reset (synchronous, active-high): ledMap=0, valid=0, busy=0, frameErr=0, state=IDLE, shift register=0, bit counter=0, synchronizers=0, edge-history registers=0.
- sck, sdi and ce each pass through SYNC_STAGES flops. sdi uses the same depth as sck, so data stays aligned with the clock edge.
- Rising-edge detect: synchronized sck=1 and the previous synchronized sck=0.
- Falling-ce detect: synchronized ce=0 and the previous synchronized ce=1.
- Timing requirement on the MCU side: sck high and low phases of at least SYNC_STAGES+1 clk periods each. ce must be set up at least 2 sck-low phases before the first rising sck edge.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: when synchronized ce=1, clear the counter and shift register and go to SHIFT. busy=1 from the cycle after entry.
  - SHIFT: on each detected sck rise, shift = {shift[FRAME_BITS-2:0], sdi_sync} and count+1. The counter is 7 bits and saturates at FRAME_BITS+1, which marks overrun; the shift register keeps shifting during overrun. On a falling-ce detect, go to COMMIT.
  - COMMIT: a single cycle.
    - If count==FRAME_BITS: ledMap<=shift, valid=1 for exactly this cycle, frameErr<=0.
    - Otherwise: ledMap is held, valid=0, frameErr<=1.
    - Then go to IDLE with busy=0.
- A frame with zero bits (ce pulse with no sck) goes through COMMIT with count=0 and sets frameErr.
- sck edges while ce is low (in IDLE) are ignored.
- Latency: valid asserts SYNC_STAGES+2 clk cycles after ce falls at the pin. ledMap becomes visible in the same cycle as valid.
- A sck rise and a ce fall detected in the same cycle: the bit is shifted and counted first, and COMMIT uses the updated count.
- If ce reasserts during COMMIT, it is seen in IDLE on the next cycle, so the new frame is not lost.
- Reset asserted mid-frame aborts the frame with no valid and no frameErr. ledMap returns to 0.
- Outputs are registered: ledMap, valid, busy and frameErr are all flop outputs.

Decomposition:
- Shared package board_pkg:
  - FRAME_BITS default
  - typedef of a 64-bit board bitmap (boardMap_t)
  - FSM state enum (spiRxState_t: IDLE, SHIFT, COMMIT)
  - square-index mapping constants shared with the transmit side
- One sub-module: sync_edge, an N-stage synchronizer with registered rise/fall pulses. Instantiate it for sck and ce; sdi uses the synchronizer path only.

Test Plan:
- Reset, then idle with sck toggling and ce=0 -> ledMap=0, valid never asserts, busy=0, frameErr=0.
- 64-bit frame 0xFFFF_0000_0000_FFFF, sck half-period 5 clk -> exactly one valid pulse SYNC_STAGES+2 cycles after ce falls; ledMap=0xFFFF00000000FFFF; frameErr=0; busy low afterwards.
- 63-bit frame after the good frame above -> no valid, frameErr=1, ledMap still 0xFFFF00000000FFFF.
- 70-bit frame whose last 64 bits are 0xA5A5A5A5A5A5A5A5 -> overrun, frameErr=1, ledMap unchanged. A following good frame 0x0123456789ABCDEF -> valid pulse, ledMap=0x0123456789ABCDEF, frameErr=0.
- Assert reset after 30 bits of a frame -> all outputs 0 the next cycle. The remaining bits with ce still high produce no valid. After ce deasserts and a fresh 64-bit frame 0x1 is sent -> ledMap=0x0000000000000001.
- Back-to-back frames with ce low for only 2 clk between them -> both frames commit with two distinct valid pulses.
